// File: rtl/guess_round_if.sv
// Handshake and status bundle between the guess round controller and its neighbours.
// The master drives start/difficulty/guess/secret; the slave returns round status.
interface guess_round_if;
    logic       start;
    logic [1:0] difficulty;
    logic       guess_valid;
    logic [6:0] guess;
    logic [6:0] secret;
    logic [2:0] state;
    logic [6:0] time_left;
    logic [3:0] attempts;
    logic       hint_high;
    logic       hint_low;
    logic       win;
    logic       lose;

    modport master (
        output start, difficulty, guess_valid, guess, secret,
        input  state, time_left, attempts, hint_high, hint_low, win, lose
    );

    modport slave (
        input  start, difficulty, guess_valid, guess, secret,
        output state, time_left, attempts, hint_high, hint_low, win, lose
    );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: countdown, guesses, hints, win/lose.
// Optional macro PENALTY_EN: wrong guesses subtract PENALTY_SEC from the countdown.
module guess_round_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned T_EASY        = 30,
    parameter int unsigned T_MED         = 60,
    parameter int unsigned T_HARD        = 90,
    parameter int unsigned MAX_ATTEMPTS  = 10,
    parameter int unsigned PENALTY_SEC   = 5
) (
    input  logic          clk,
    input  logic          reset,
    guess_round_if.slave  bus
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);
`ifdef PENALTY_EN
    localparam bit PenaltyOn = 1'b1;
`else
    localparam bit PenaltyOn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StPlay = 3'd2,
        StWon  = 3'd3,
        StLost = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [6:0]    time_q, time_d;
    logic [3:0]    att_q, att_d;
    logic          hh_q, hh_d;
    logic          hl_q, hl_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    diff_q, diff_d;

    logic       tick;
    logic       start_ok;
    logic       guess_in;
    logic       guess_hit;
    logic       guess_wrong;
    logic       out_of_tries;
    logic       time_out;
    logic [3:0] att_inc;
    logic [6:0] load_time;
    logic [7:0] dec;
    logic [6:0] time_after;

    // Event decode for the current cycle
    always_comb begin
        tick         = (state_q == StPlay) && (presc_q == PrescLast);
        start_ok     = bus.start && (bus.difficulty != 2'd0);
        guess_in     = (state_q == StPlay) && bus.guess_valid;
        guess_hit    = guess_in && (bus.guess == bus.secret);
        guess_wrong  = guess_in && !guess_hit;
        att_inc      = (att_q == 4'hF) ? att_q : att_q + 4'd1;
        out_of_tries = guess_wrong && (({1'b0, att_q} + 5'd1) == 5'(MAX_ATTEMPTS));

        unique case (diff_q)
            2'd1:    load_time = 7'(T_EASY);
            2'd2:    load_time = 7'(T_MED);
            2'd3:    load_time = 7'(T_HARD);
            default: load_time = 7'd0;
        endcase

        // Tick and penalty are combined into one saturating subtraction
        dec = {7'd0, tick};
        if (PenaltyOn && guess_wrong) begin
            dec = dec + 8'(PENALTY_SEC);
        end
        time_out   = (dec != 8'd0) && ({1'b0, time_q} <= dec);
        time_after = time_out ? 7'd0 : time_q - dec[6:0];
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        att_d   = att_q;
        hh_d    = hh_q;
        hl_d    = hl_q;
        presc_d = presc_q;
        diff_d  = diff_q;

        case (state_q)
            StIdle, StWon, StLost: begin
                if (start_ok) begin
                    diff_d  = bus.difficulty;
                    state_d = StArm;
                end
            end
            StArm: begin
                time_d  = load_time;
                att_d   = 4'd0;
                hh_d    = 1'b0;
                hl_d    = 1'b0;
                presc_d = '0;
                state_d = StPlay;
            end
            StPlay: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                time_d  = time_after;
                if (guess_in) begin
                    att_d = att_inc;
                    if (guess_hit) begin
                        hh_d = 1'b0;
                        hl_d = 1'b0;
                    end else begin
                        hh_d = bus.guess > bus.secret;
                        hl_d = bus.guess < bus.secret;
                    end
                end
                // A correct guess beats a same-cycle timeout
                if (guess_hit) begin
                    state_d = StWon;
                end else if (time_out || out_of_tries) begin
                    state_d = StLost;
                end
            end
            default: state_d = StIdle;
        endcase

        win_d  = (state_d == StWon);
        lose_d = (state_d == StLost);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            time_q  <= 7'd0;
            att_q   <= 4'd0;
            hh_q    <= 1'b0;
            hl_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            presc_q <= '0;
            diff_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            att_q   <= att_d;
            hh_q    <= hh_d;
            hl_q    <= hl_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            presc_q <= presc_d;
            diff_q  <= diff_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.time_left = time_q;
    assign bus.attempts  = att_q;
    assign bus.hint_high = hh_q;
    assign bus.hint_low  = hl_q;
    assign bus.win       = win_q;
    assign bus.lose      = lose_q;

endmodule
